dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameters SHALL be:
- STARVE_LIMIT, default 4: consecutive lost DMA cycles before DMA is forced a grant.
- MAX_BURST, default 4: maximum consecutive locked DMA beats.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  M-stage load/store valid this cycle.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_byteen  in  4  CPU byte enables; 0000 means read.
- cpu_rdata  out  32  combinational copy of m_data_rdata.
- cpu_stall  out  1  CPU request not served this cycle; hold M stage.
- dma_req  in  1  DMA requests a beat.
- dma_lock  in  1  DMA requests burst continuation.
- dma_addr  in  32  DMA byte address.
- dma_wdata  in  32  DMA store data.
- dma_byteen  in  4  DMA byte enables; 0000 means read.
- dma_gnt  out  1  DMA beat performed this cycle.
- dma_rvalid  out  1  registered pulse, DMA read data valid.
- dma_rdata  out  32  registered DMA read data.
- m_data_addr  out  32  memory address.
- m_data_wdata  out  32  memory write data.
- m_data_byteen  out  4  memory byte enables; write at clk edge.
- m_data_rdata  in  32  memory read data, combinational from m_data_addr.

Function
REQ-003 Grant decision SHALL be combinational from registered state and current requests; at most one owner per cycle.
REQ-004 States SHALL be:
- ARB: normal arbitration.
- BURST: DMA holds the port.
- YIELD: one-cycle hand-back to the CPU.
REQ-005 In ARB, arbitration SHALL be:
- dma_req only: DMA granted.
- cpu_req only: CPU granted.
- Both with starve_cnt < STARVE_LIMIT: CPU granted, starve_cnt increments.
- Both with starve_cnt == STARVE_LIMIT: DMA granted, cpu_stall=1.
REQ-006 starve_cnt SHALL clear on every DMA grant and when dma_req=0, and SHALL saturate at STARVE_LIMIT.
REQ-007 A DMA grant in ARB or BURST with dma_lock=1 SHALL enter or stay in BURST; beat_cnt counts granted beats within the burst, from 1.
REQ-008 In BURST, DMA SHALL be granted while dma_req=1; cpu_stall=cpu_req.
REQ-009 BURST SHALL leave:
- to ARB when dma_req=0 or dma_lock=0 (that cycle arbitrated as ARB).
- to YIELD after beat MAX_BURST if cpu_req=1, else to ARB.
REQ-010 In YIELD, the CPU SHALL be granted if cpu_req=1 and DMA refused; next state ARB.
REQ-011 When neither side is granted, m_data_byteen SHALL be 0000 and m_data_addr/m_data_wdata SHALL be 0.
REQ-012 Granted owner's addr/wdata/byteen SHALL drive memory unmodified; no address alignment checking.
REQ-013 dma_rvalid SHALL pulse one cycle after a granted DMA beat with dma_byteen=0000; dma_rdata SHALL capture m_data_rdata on that edge and otherwise hold.
REQ-014 cpu_stall SHALL equal cpu_req AND NOT CPU-granted; dma_gnt SHALL be 0 when dma_req=0.
REQ-015 Counter widths SHALL hold STARVE_LIMIT and MAX_BURST without wrap.

Reset
REQ-016 On reset=1 at a clk edge:
- state=ARB; starve_cnt=0; beat_cnt=0.
- dma_rvalid=0; dma_rdata=0.
REQ-017 Reset SHALL override any in-progress burst or pending rvalid; no memory write is suppressed in the reset cycle itself, since grants are combinational.

Verification
REQ-018 The bench SHALL cover:
- CPU-only lw at 0x10, memory 0xDEADBEEF: cpu_rdata=0xDEADBEEF, cpu_stall=0, dma_gnt=0.
- Both requesting continuously, lock=0: CPU wins 4 cycles, DMA wins 5th with cpu_stall=1; pattern repeats.
- DMA locked 6-beat burst with cpu_req=1: 4 DMA beats, 1 YIELD CPU beat, then DMA re-arbitrated.
- DMA read of 0x20 holding 0x12345678: dma_rvalid=1 and dma_rdata=0x12345678 next cycle.
- Reset during beat 2 of a burst: next cycle state ARB, dma_rvalid=0, CPU granted if requesting.
- Idle cycle: m_data_byteen=0000, m_data_addr=0.

Source files
------------

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - single-port data memory arbiter between CPU M-stage and a DMA engine
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   cpu_req/addr/wdata/byteen   : CPU access request (byteen 0000 = read)
//   cpu_rdata, cpu_stall        : CPU read data (combinational), hold-M-stage indication
//   dma_req/lock/addr/wdata/byteen : DMA beat request, burst continuation, access fields
//   dma_gnt, dma_rvalid, dma_rdata : beat performed, registered read-data pulse and data
//   m_data_addr/wdata/byteen    : memory port driven by the granted owner (zero when idle)
//   m_data_rdata                : memory read data, combinational from m_data_addr
module dm_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

  typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_YIELD} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          cpu_gnt;
  logic          dma_win;
  logic [BW-1:0] beat_next;

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_win   = 1'b0;
    state_d   = ST_ARB;
    starve_d  = starve_q;
    beat_d    = '0;

    case (state_q)
      ST_YIELD: cpu_gnt = cpu_req;
      // A dropped dma_req inside a burst is arbitrated as ARB; with no DMA
      // request that reduces to serving the CPU.
      ST_BURST: begin
        if (dma_req) dma_win = 1'b1;
        else         cpu_gnt = cpu_req;
      end
      default: begin
        if (dma_req && (!cpu_req || starve_q == STARVE_MAX)) dma_win = 1'b1;
        else                                                 cpu_gnt = cpu_req;
      end
    endcase

    // Starvation counts only cycles where DMA asked and lost.
    if (!dma_req || dma_win)        starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);

    beat_next = ((state_q == ST_BURST) ? beat_q : '0) + BW'(1);
    if (dma_win && dma_lock) begin
      if (beat_next >= BURST_MAX) begin
        state_d = cpu_req ? ST_YIELD : ST_ARB;
      end else begin
        state_d = ST_BURST;
        beat_d  = beat_next;
      end
    end

    rvalid_d = dma_win && (dma_byteen == 4'b0000);
    rdata_d  = rvalid_d ? m_data_rdata : rdata_q;
  end

  always_comb begin
    m_data_addr   = 32'h0;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'b0000;
    if (dma_win) begin
      m_data_addr   = dma_addr;
      m_data_wdata  = dma_wdata;
      m_data_byteen = dma_byteen;
    end else if (cpu_gnt) begin
      m_data_addr   = cpu_addr;
      m_data_wdata  = cpu_wdata;
      m_data_byteen = cpu_byteen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_ARB;
      starve_q <= '0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cpu_rdata  = m_data_rdata;
  assign cpu_stall  = cpu_req && !cpu_gnt;
  assign dma_gnt    = dma_win;
  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized and directed bench for dm_arbiter with a cycle-level reference model
module tb_dm_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int MAX_BURST    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_stall;
  logic        dma_req, dma_lock;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_byteen;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;

  logic [31:0] mem [64];

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 0;

  // Reference model state, expressed as plain counters.
  int   m_starve = 0;
  int   m_beats  = 0;   // beats already granted in the current locked burst, 0 = none
  bit   m_yield  = 0;
  bit   m_rvalid = 0;
  logic [31:0] m_rdata = 32'h0;
  bit   e_dma, e_cpu;

  always #5 clk = ~clk;

  assign m_data_rdata = mem[m_data_addr[7:2]];

  dm_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_byteen(dma_byteen), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_data_rdata(m_data_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Compare process: expected grant from the arbitration rules, then every output.
  always @(negedge clk) begin
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    e_dma = 0;
    e_cpu = 0;
    if (m_yield)                      e_cpu = cpu_req;
    else if (m_beats > 0 && dma_req)  e_dma = 1;
    else if (dma_req && (!cpu_req || m_starve == STARVE_LIMIT)) e_dma = 1;
    else                              e_cpu = cpu_req;
    ea = 32'h0; ew = 32'h0; eb = 4'h0;
    if (e_dma)      begin ea = dma_addr; ew = dma_wdata; eb = dma_byteen; end
    else if (e_cpu) begin ea = cpu_addr; ew = cpu_wdata; eb = cpu_byteen; end
    if (check_en) begin
      chk("m_dma_gnt",    {31'b0, dma_gnt},   {31'b0, e_dma});
      chk("m_cpu_stall",  {31'b0, cpu_stall}, {31'b0, cpu_req && !e_cpu});
      chk("m_addr",       m_data_addr,        ea);
      chk("m_wdata",      m_data_wdata,       ew);
      chk("m_byteen",     {28'b0, m_data_byteen}, {28'b0, eb});
      chk("m_cpu_rdata",  cpu_rdata,          mem[ea[7:2]]);
      chk("m_dma_rvalid", {31'b0, dma_rvalid}, {31'b0, m_rvalid});
      chk("m_dma_rdata",  dma_rdata,          m_rdata);
    end
  end

  // Model advance and memory write at the clock edge.
  always @(posedge clk) begin
    if (e_dma && dma_byteen != 4'b0)
      mem[dma_addr[7:2]] <= apply_be(mem[dma_addr[7:2]], dma_wdata, dma_byteen);
    else if (e_cpu && cpu_byteen != 4'b0)
      mem[cpu_addr[7:2]] <= apply_be(mem[cpu_addr[7:2]], cpu_wdata, cpu_byteen);
    if (reset) begin
      m_starve = 0; m_beats = 0; m_yield = 0; m_rvalid = 0; m_rdata = 32'h0;
    end else begin
      m_rvalid = e_dma && (dma_byteen == 4'b0);
      if (m_rvalid) m_rdata = mem[dma_addr[7:2]];
      if (!dma_req || e_dma)            m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
      m_yield = 0;
      if (e_dma && dma_lock) begin
        if (m_beats + 1 >= MAX_BURST) begin
          m_beats = 0;
          m_yield = cpu_req;
        end else begin
          m_beats = m_beats + 1;
        end
      end else begin
        m_beats = 0;
      end
    end
  end

  task automatic drive(input bit rst, input bit c_req, input logic [31:0] c_addr,
                       input logic [3:0] c_be, input bit d_req, input bit d_lock,
                       input logic [31:0] d_addr, input logic [3:0] d_be);
    @(posedge clk);
    #1;
    reset = rst; cpu_req = c_req; cpu_addr = c_addr; cpu_byteen = c_be;
    cpu_wdata = $urandom; dma_req = d_req; dma_lock = d_lock; dma_addr = d_addr;
    dma_byteen = d_be; dma_wdata = $urandom;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h12345678;
    reset = 1; cpu_req = 0; cpu_addr = 0; cpu_wdata = 0; cpu_byteen = 0;
    dma_req = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0; dma_byteen = 0;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check_en = 1;

    // Idle after reset.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_rvalid", {31'b0, dma_rvalid}, 32'h0);
    chk("rst_rdata",  dma_rdata, 32'h0);
    chk("idle_byteen", {28'b0, m_data_byteen}, 32'h0);
    chk("idle_addr",  m_data_addr, 32'h0);

    // CPU-only load from 0x10.
    drive(0, 1, 32'h10, 4'h0, 0, 0, 0, 0);
    chk("lw_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("lw_stall", {31'b0, cpu_stall}, 32'h0);
    chk("lw_dgnt",  {31'b0, dma_gnt}, 32'h0);

    // Both requesting unlocked: CPU x4 then DMA, twice.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 5; k++) begin
        drive(0, 1, 32'h40, 4'h0, 1, 0, 32'h20, 4'h0);
        chk("starve_dgnt",  {31'b0, dma_gnt},   (k == 4) ? 32'h1 : 32'h0);
        chk("starve_stall", {31'b0, cpu_stall}, (k == 4) ? 32'h1 : 32'h0);
      end

    // DMA read of 0x20, data visible the next cycle.
    drive(0, 0, 0, 0, 1, 0, 32'h20, 4'h0);
    chk("rd_gnt", {31'b0, dma_gnt}, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_rvalid", {31'b0, dma_rvalid}, 32'h1);
    chk("rd_rdata",  dma_rdata, 32'h12345678);
    chk("idle2_byteen", {28'b0, m_data_byteen}, 32'h0);
    chk("idle2_addr", m_data_addr, 32'h0);

    // Locked 6-beat burst; CPU joins after the first beat.
    drive(0, 0, 0, 0, 1, 1, 32'h80, 4'hF);
    chk("b1_gnt", {31'b0, dma_gnt}, 32'h1);
    for (int k = 2; k <= 4; k++) begin
      drive(0, 1, 32'h44, 4'h0, 1, 1, 32'h80 + 32'(k * 4), 4'hF);
      chk("bN_gnt",   {31'b0, dma_gnt},   32'h1);
      chk("bN_stall", {31'b0, cpu_stall}, 32'h1);
    end
    drive(0, 1, 32'h44, 4'h0, 1, 1, 32'h94, 4'hF);
    chk("yield_dgnt",  {31'b0, dma_gnt},   32'h0);
    chk("yield_stall", {31'b0, cpu_stall}, 32'h0);
    drive(0, 1, 32'h44, 4'h0, 1, 1, 32'h94, 4'hF);
    chk("rearb_dgnt", {31'b0, dma_gnt}, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during beat 2 of a read burst.
    drive(0, 0, 0, 0, 1, 1, 32'h20, 4'h0);
    drive(1, 1, 32'h10, 4'h0, 1, 1, 32'h24, 4'h0);
    chk("rb2_gnt", {31'b0, dma_gnt}, 32'h1);
    drive(0, 1, 32'h10, 4'h0, 1, 1, 32'h28, 4'h0);
    chk("rst_mid_dgnt",   {31'b0, dma_gnt},    32'h0);
    chk("rst_mid_stall",  {31'b0, cpu_stall},  32'h0);
    chk("rst_mid_rvalid", {31'b0, dma_rvalid}, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0), $urandom,
            ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), $urandom,
            ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
